// File: rtl/gptp_rx_pkg.sv
// Shared constants and types for the gPTP receive frame FIFO.
// EtherType values, frame geometry, entry layout and the parser state encoding.
package gptp_rx_pkg;

  localparam logic [15:0] ETHERTYPE_GPTP = 16'h88F7;
  localparam logic [15:0] TPID_VLAN      = 16'h8100;

  localparam int ETH_HDR_BYTES  = 14;
  localparam int VLAN_TAG_BYTES = 4;
  localparam int PTP_MSG_BYTES  = 44;
  localparam int MSG_W          = PTP_MSG_BYTES * 8;
  localparam int TS_W           = 80;
  localparam int ENTRY_W        = 432;

  localparam logic [3:0] MAJOR_SDO_ID = 4'h1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PAY  = 3'd2,
    ST_TAIL = 3'd3,
    ST_SKIP = 3'd4
  } rx_state_e;

endpackage

// File: rtl/gptp_fwft_fifo.sv
// First-word-fall-through FIFO with a registered head word.
// Fullness is judged before a same-cycle pop, so a push into a full FIFO is
// always rejected and reported on push_drop.
module gptp_fwft_fifo #(
  parameter int WIDTH = 432,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     push_drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] head_s;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] rd_nxt_s;
  logic [LVL_W-1:0] level_r;
  logic [LVL_W-1:0] level_s;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_s     = (level_r == LVL_W'(DEPTH));
  assign empty_s    = (level_r == {LVL_W{1'b0}});
  assign push_ok_s  = push & ~full_s;
  assign pop_ok_s   = pop & ~empty_s;
  assign rd_nxt_s   = rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
  assign push_drop  = push & full_s;
  assign head_data  = head_r;
  assign head_valid = ~empty_s;
  assign level      = level_r;

  // Next occupancy and next head word, given this cycle's push/pop.
  always_comb begin
    level_s = level_r;
    head_s  = head_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_s = level_r + {{(LVL_W-1){1'b0}}, 1'b1};
      2'b01:   level_s = level_r - {{(LVL_W-1){1'b0}}, 1'b1};
      default: level_s = level_r;
    endcase
    if (pop_ok_s) begin
      if (level_r == {{(LVL_W-1){1'b0}}, 1'b1}) begin
        // Only entry leaves; a simultaneous push becomes the new head.
        if (push_ok_s) begin
          head_s = push_data;
        end else begin
          head_s = head_r;
        end
      end else begin
        head_s = mem_r[rd_nxt_s];
      end
    end else if (push_ok_s && empty_s) begin
      head_s = push_data;
    end else begin
      head_s = head_r;
    end
  end

  // Storage array; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and registered head word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
      head_r   <= {WIDTH{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_nxt_s;
      end
      level_r <= level_s;
      head_r  <= head_s;
    end
  end

endmodule

// File: rtl/gptp_rx_frame_fifo.sv
// gPTP ingress filter and frame FIFO.
// Parses the MAC byte stream, keeps frames with EtherType 0x88F7 and
// majorSdoId 1, timestamps them at byte 0 and queues {timestamp, 44-byte
// PTP message} entries. Optional build macro GPTP_RX_VLAN_EN accepts a
// single 802.1Q tag (stripped); without it, tagged frames are skipped.
module gptp_rx_frame_fifo
  import gptp_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  mac_rx_data,
  input  logic                        mac_rx_vaild,
  input  logic                        mac_rx_last,
  input  logic                        mac_rx_err,
  input  logic [31:0]                 rtc_nanosec_field,
  input  logic [31:0]                 rtc_sec_field,
  input  logic [15:0]                 rtc_epoch_field,
  output logic [ENTRY_W-1:0]          gptp_rv_data,
  output logic                        gptp_rv_vaild,
  input  logic                        gptp_rv_ready,
  output logic [CNT_W-1:0]            rx_drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  rx_state_e          state_r;
  rx_state_e          state_s;
  logic [6:0]         bcnt_r;
  logic               vlan_r;
  logic               vlan_s;
  logic [7:0]         et_hi_r;
  logic [15:0]        et_s;
  logic [TS_W-1:0]    ts_r;
  logic [MSG_W-1:0]   msg_r;
  logic [MSG_W-1:0]   msg_s;
  logic [ENTRY_W-1:0] cap_r;
  logic               commit_s;
  logic               commit_r;
  logic               push_r;
  logic [ENTRY_W-1:0] push_data_r;
  logic               parse_drop_s;
  logic               fifo_drop_s;
  logic [CNT_W-1:0]   drop_cnt_r;
  logic [6:0]         pay_start_s;
  logic [6:0]         pay_end_s;
  logic [6:0]         et_lo_pos_s;

  // Payload window moves back by the tag length once a VLAN tag is seen.
  assign pay_start_s = vlan_r ? 7'(ETH_HDR_BYTES + VLAN_TAG_BYTES) : 7'(ETH_HDR_BYTES);
  assign pay_end_s   = pay_start_s + 7'(PTP_MSG_BYTES - 1);
  assign et_lo_pos_s = pay_start_s - 7'd1;
  assign et_s        = {et_hi_r, mac_rx_data};
  assign msg_s       = {msg_r[MSG_W-9:0], mac_rx_data};
  assign rx_drop_cnt = drop_cnt_r;

  // Parser next state, commit and drop decisions for the current byte.
  always_comb begin
    state_s      = state_r;
    vlan_s       = vlan_r;
    commit_s     = 1'b0;
    parse_drop_s = 1'b0;
    if (mac_rx_vaild) begin
      case (state_r)
        ST_IDLE: begin
          vlan_s  = 1'b0;
          state_s = ST_HDR;
        end
        ST_HDR: begin
          if (bcnt_r == et_lo_pos_s) begin
            if (et_s == ETHERTYPE_GPTP) begin
              state_s = ST_PAY;
`ifdef GPTP_RX_VLAN_EN
            end else if ((et_s == TPID_VLAN) && !vlan_r) begin
              vlan_s  = 1'b1;
              state_s = ST_HDR;
`endif
            end else begin
              state_s = ST_SKIP;
            end
          end else begin
            state_s = ST_HDR;
          end
        end
        ST_PAY: begin
          if ((bcnt_r == pay_start_s) && (mac_rx_data[7:4] != MAJOR_SDO_ID)) begin
            state_s = ST_SKIP;
          end else if (bcnt_r == pay_end_s) begin
            state_s = ST_TAIL;
          end else begin
            state_s = ST_PAY;
          end
        end
        ST_TAIL: state_s = ST_TAIL;
        ST_SKIP: state_s = ST_SKIP;
        default: state_s = ST_IDLE;
      endcase
      if (mac_rx_last) begin
        state_s = ST_IDLE;
        case (state_r)
          ST_HDR: parse_drop_s = 1'b1;
          ST_PAY: begin
            if (bcnt_r == pay_end_s) begin
              commit_s     = ~mac_rx_err;
              parse_drop_s = mac_rx_err;
            end else begin
              parse_drop_s = 1'b1;
            end
          end
          ST_TAIL: begin
            commit_s     = ~mac_rx_err;
            parse_drop_s = mac_rx_err;
          end
          default: parse_drop_s = 1'b0;
        endcase
      end
    end else begin
      state_s = state_r;
    end
  end

  // Parser state, byte counter, timestamp and message shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      bcnt_r  <= 7'd0;
      vlan_r  <= 1'b0;
      et_hi_r <= 8'd0;
      ts_r    <= {TS_W{1'b0}};
      msg_r   <= {MSG_W{1'b0}};
    end else begin
      state_r <= state_s;
      vlan_r  <= vlan_s;
      if (mac_rx_vaild) begin
        if (state_r == ST_IDLE) begin
          ts_r   <= {rtc_epoch_field, rtc_sec_field, rtc_nanosec_field};
          bcnt_r <= 7'd1;
        end else if ((state_r == ST_HDR) || (state_r == ST_PAY)) begin
          bcnt_r <= bcnt_r + 7'd1;
        end
        if ((state_r == ST_HDR) && (bcnt_r == et_lo_pos_s - 7'd1)) begin
          et_hi_r <= mac_rx_data;
        end
        if (state_r == ST_PAY) begin
          msg_r <= msg_s;
        end
      end
    end
  end

  // Two-stage commit: capture on the last-byte edge, push one edge later,
  // so a frame starting right after last cannot disturb the queued word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commit_r    <= 1'b0;
      cap_r       <= {ENTRY_W{1'b0}};
      push_r      <= 1'b0;
      push_data_r <= {ENTRY_W{1'b0}};
    end else begin
      commit_r <= commit_s;
      if (commit_s) begin
        cap_r <= {ts_r, (state_r == ST_PAY) ? msg_s : msg_r};
      end
      push_r <= commit_r;
      if (commit_r) begin
        push_data_r <= cap_r;
      end
    end
  end

  // Drop counter: parser drops and FIFO overflow may land in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_r <= {CNT_W{1'b0}};
    end else begin
      drop_cnt_r <= drop_cnt_r + CNT_W'(parse_drop_s) + CNT_W'(fifo_drop_s);
    end
  end

  gptp_fwft_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push       (push_r),
    .push_data  (push_data_r),
    .pop        (gptp_rv_ready),
    .head_data  (gptp_rv_data),
    .head_valid (gptp_rv_vaild),
    .level      (fifo_level),
    .push_drop  (fifo_drop_s)
  );

endmodule

// File: doc/gptp_rx_frame_fifo.md
Name: gptp_rx_frame_fifo

Overview:
- Ingress stage directly upstream of the gPTP receive parser. Takes the MAC receive byte stream and filters gPTP frames (EtherType 0x88F7, majorSdoId 1).
- Timestamps each frame at its first byte from the RTC. Packs the 44-byte PTP message plus an 80-bit ingress timestamp into one 432-bit entry.
- Buffers entries in a first-word-fall-through FIFO, so the head entry is held stable on gptp_rv_data until it is consumed.

Parameters:
- FIFO_DEPTH, 4: number of 432-bit entries; power of two, minimum 2.
- CNT_W, 16: width of the drop counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- mac_rx_data  in  8  received byte, destination-MAC first
- mac_rx_vaild  in  1  byte valid; gaps allowed inside a frame
- mac_rx_last  in  1  last byte of frame, qualified by vaild
- mac_rx_err  in  1  FCS/PHY error, sampled with last
- rtc_nanosec_field  in  32  live RTC nanoseconds
- rtc_sec_field  in  32  live RTC seconds
- rtc_epoch_field  in  16  live RTC epoch
- gptp_rv_data  out  432  head entry: [431:352] = {epoch, sec, ns} timestamp; [351:0] = PTP bytes 0..43, byte 0 in [351:344]
- gptp_rv_vaild  out  1  FIFO not empty
- gptp_rv_ready  in  1  pop head when vaild & ready
- rx_drop_cnt  out  CNT_W  count of frames dropped for overflow, short length or error; wraps
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (reset=0, async): FSM to IDLE, FIFO emptied, gptp_rv_vaild=0, gptp_rv_data=0, rx_drop_cnt=0, fifo_level=0.
- The block never back-pressures the MAC: every byte with vaild=1 is consumed.
- Byte counter bcnt counts accepted bytes within a frame.
- FSM states:
  - IDLE: on the first valid byte, latch the RTC triple into ts_reg (timestamp = edge accepting byte 0). Set bcnt=1 and go to HDR.
  - HDR: bytes 1..13. Bytes 12-13 are compared with 0x88F7. On mismatch, go to SKIP. After byte 13 matches, go to PAY.
  - PAY: bytes 14..57 are shifted MSB-first into msg_reg. Byte 14 must have its upper nibble = 0x1 (majorSdoId); otherwise go to SKIP. After byte 57, go to TAIL.
  - TAIL: ignores padding/FCS until last.
  - SKIP: non-gPTP frame; ignored until last. Not counted as a drop.
- mac_rx_last handling, in any state:
  - Return to IDLE on the same edge.
  - Commit only if the state is TAIL, or PAY with byte 57 carrying last, and err=0.
  - last while in HDR or PAY before byte 57 gptp frame: drop, rx_drop_cnt += 1.
  - err=1 on a gPTP frame: drop, counted.
  - A single-byte frame (last on byte 0) returns straight to IDLE, uncounted.
- Commit is a one-cycle registered push pulse on the edge after last. A new frame may start on that same edge; ts_reg/msg_reg are double-registered into the push word so they are not overwritten.
- FIFO behaviour:
  - Push when full: entry discarded, rx_drop_cnt += 1. Fullness is judged before a same-cycle pop, so push+pop while full drops.
  - Pop when empty: ignored.
  - Push+pop while not full and not empty: level unchanged.
- Latency: gptp_rv_vaild rises 2 edges after the edge accepting last, when the FIFO was empty.
- gptp_rv_data changes only on a pop or a push into an empty FIFO. It holds while vaild & !ready.
- Pointers wrap modulo FIFO_DEPTH. level has one extra bit to distinguish full from empty.
- Reset mid-frame: the partial frame is discarded; the next frame is parsed from IDLE.

Optional Feature:
- Macro GPTP_RX_VLAN_EN.
- Defined: in HDR, bytes 12-13 = 0x8100 extend the header by 4 bytes; EtherType is checked at bytes 16-17 and the payload spans bytes 18..61. The VLAN tag is stripped, not stored. A double tag goes to SKIP.
- Undefined: 0x8100 frames go to SKIP.

Decomposition:
- Package gptp_rx_pkg holds:
  - ETHERTYPE_GPTP=16'h88F7, TPID_VLAN=16'h8100
  - ETH_HDR_BYTES=14, PTP_MSG_BYTES=44, TS_W=80, ENTRY_W=432
  - MAJOR_SDO_ID=4'h1
  - FSM state enum
- One sub-module: gptp_fwft_fifo (parameterised width/depth, registered head output, level output).

Test Plan:
- 60-byte Sync frame, EtherType 0x88F7, byte14=0x10, RTC={16'h0001,32'h5,32'd1000} at byte 0 -> vaild 2 edges after last; data[431:352]=0x0001_00000005_000003E8; data[351:344]=0x10; drop_cnt=0.
- Frame with EtherType 0x0800, then a gPTP frame back-to-back (no idle cycle) -> exactly one entry, from the gPTP frame; drop_cnt=0.
- gPTP frame with last at byte 40 -> no entry; drop_cnt=1. gPTP frame with err=1 on last -> no entry; drop_cnt=2.
- FIFO_DEPTH=4, ready=0, six valid frames -> level=4, drop_cnt=2; head entry is frame 1 and stays stable. Then ready=1 -> frames 1..4 popped in order; vaild falls after the 4th pop.
- Push coincident with pop while full -> entry dropped, level stays 4. Push+pop at level 2 -> level stays 2.
- Assert reset at byte 30 of a frame, release, send a valid frame -> only the second frame is stored. With GPTP_RX_VLAN_EN, a 64-byte tagged frame (VID 5) -> same payload/timestamp as untagged.
